// File: rtl/vga_scanout.sv
// 640x480@60 scanout of a 160x120x3 framebuffer, 4x4 replication, 2 pixel ticks counter-to-pin.
// Define SCANOUT_BORDER_EN to force a white one-pixel framebuffer border for screen alignment.
module vga_scanout #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SCALE_SHIFT = 2,
  parameter int FB_WIDTH    = 160
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [14:0] rd_addr,
  output logic        rd_en,
  input  logic [2:0]  rd_data,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic [9:0]  VGA_R,
  output logic [9:0]  VGA_G,
  output logic [9:0]  VGA_B,
  output logic        vblank_start
);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic        r_pix_en, r_vga_clk, r_vblank;
  logic [9:0]  r_h_cnt, r_v_cnt;
  logic        w_h_last, w_v_last, w_active, w_hs, w_vs;
  logic [14:0] w_fx, w_fy, w_row, w_addr;
  logic        r_rd_en, r_hs1, r_vs1;
  logic [14:0] r_rd_addr;
  logic        r_hs, r_vs, r_blank_n;
  logic [9:0]  r_r, r_g, r_b;
  logic [2:0]  w_colour;

  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);
  assign w_active = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_hs     = !((r_h_cnt >= HS_BEG) && (r_h_cnt <= HS_END));
  assign w_vs     = !((r_v_cnt >= VS_BEG) && (r_v_cnt <= VS_END));

  assign w_fx = 15'(r_h_cnt >> SCALE_SHIFT);
  assign w_fy = 15'(r_v_cnt >> SCALE_SHIFT);

  // y*160 as shift-add; other widths fall back to a constant multiply
  if (FB_WIDTH == 160) begin : g_row_shift
    assign w_row = (w_fy << 7) + (w_fy << 5);
  end else begin : g_row_mul
    assign w_row = 15'(w_fy * FB_WIDTH);
  end
  assign w_addr = w_row + w_fx;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pix_en  <= 1'b0;
      r_vga_clk <= 1'b0;
      r_vblank  <= 1'b0;
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
    end else begin
      r_pix_en  <= ~r_pix_en;
      r_vga_clk <= ~r_pix_en;
      r_vblank  <= 1'b0;
      if (r_pix_en) begin
        if (w_h_last) begin
          r_h_cnt <= '0;
          r_v_cnt <= w_v_last ? 10'd0 : r_v_cnt + 10'd1;
          if (r_v_cnt == V_ACT - 10'd1) r_vblank <= 1'b1;
        end else begin
          r_h_cnt <= r_h_cnt + 10'd1;
        end
      end
    end
  end

`ifdef SCANOUT_BORDER_EN
  localparam logic [14:0] FX_LAST = 15'(FB_WIDTH - 1);
  localparam logic [14:0] FY_LAST = 15'((V_ACTIVE >> SCALE_SHIFT) - 1);
  logic r_border1;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_border1 <= 1'b0;
    end else if (r_pix_en) begin
      r_border1 <= (w_fx == '0) || (w_fx == FX_LAST) || (w_fy == '0) || (w_fy == FY_LAST);
    end
  end
  assign w_colour = r_border1 ? 3'b111 : rd_data;
`else
  assign w_colour = rd_data;
`endif

  // Stage 1 issues the read; the output stage catches rd_data one tick later
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_hs1     <= 1'b1;
      r_vs1     <= 1'b1;
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_blank_n <= 1'b0;
      r_r       <= '0;
      r_g       <= '0;
      r_b       <= '0;
    end else if (r_pix_en) begin
      r_rd_en   <= w_active;
      if (w_active) r_rd_addr <= w_addr;
      r_hs1     <= w_hs;
      r_vs1     <= w_vs;
      r_hs      <= r_hs1;
      r_vs      <= r_vs1;
      r_blank_n <= r_rd_en;
      r_r       <= r_rd_en ? {10{w_colour[2]}} : 10'd0;
      r_g       <= r_rd_en ? {10{w_colour[1]}} : 10'd0;
      r_b       <= r_rd_en ? {10{w_colour[0]}} : 10'd0;
    end
  end

  assign rd_addr      = r_rd_addr;
  assign rd_en        = r_rd_en;
  assign VGA_CLK      = r_vga_clk;
  assign VGA_HS       = r_hs;
  assign VGA_VS       = r_vs;
  assign VGA_BLANK_N  = r_blank_n;
  assign VGA_SYNC_N   = 1'b0;
  assign VGA_R        = r_r;
  assign VGA_G        = r_g;
  assign VGA_B        = r_b;
  assign vblank_start = r_vblank;
endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout with a shortened vertical frame (12 active lines) so several frames fit in a short run.
// Reference outputs are derived from the number of clks since reset release.
module tb_vga_scanout;
  localparam int VA = 12, VFP = 2, VSY = 2, VBP = 2;
  localparam int HT = 800;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FT = HT * VT;
`ifdef SCANOUT_BORDER_EN
  localparam int EDGE_B = 1023;
`else
  localparam int EDGE_B = 0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [14:0] rd_addr;
  logic        rd_en;
  logic [2:0]  rd_data = 3'b000;
  logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, vblank_start;
  logic [9:0]  VGA_R, VGA_G, VGA_B;

  logic [2:0]  mem [0:19199];
  int          n_tests = 0;
  int          n_fail = 0;
  int          k = 0;
  logic [14:0] exp_addr = '0;
  bit          meas_on = 1'b1;
  int hs_low_cnt = 0, vs_low_cnt = 0, vb_cnt = 0;
  int hs_fall1 = -1, hs_fall2 = -1, vs_fall1 = -1, vs_fall2 = -1, vb1 = -1, vb2 = -1;
  logic hs_prev = 1'b1, vs_prev = 1'b1;

  always #5 clk = ~clk;

  vga_scanout #(.V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)) dut (
    .clk(clk), .resetn(resetn), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_SYNC_N(VGA_SYNC_N), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .vblank_start(vblank_start)
  );

  // Framebuffer RAM: one-clk read latency, drives all-ones when not strobed
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 3'b111;

  // Clk edges since reset release
  always @(posedge clk or negedge resetn) begin
    if (!resetn) k <= 0;
    else k <= k + 1;
  end

  function automatic int pix_colour(input int h, input int v);
    int c;
    c = int'(mem[(v / 4) * 160 + h / 4]);
`ifdef SCANOUT_BORDER_EN
    if (h / 4 == 0 || h / 4 == 159 || v / 4 == 0 || v / 4 == VA / 4 - 1) c = 7;
`endif
    return c;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (k=%0d)", name, act, exp, k);
    end
  endtask

  task automatic wait_k(input int target);
    int guard;
    guard = 0;
    while (k < target && guard < 100000) begin
      @(negedge clk);
      guard++;
    end
    if (k != target) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_k: reached k=%0d, expected %0d", k, target);
    end
  endtask

  // Outputs after m pixel ticks reflect screen position m-2; the read side reflects position m-1
  always @(negedge clk) begin : cmp
    int m, p, h, v, col;
    logic e_en, e_hs, e_vs, e_bl, e_vb, e_vc;
    logic [9:0] e_r, e_g, e_b;
    logic [63:0] e_vec, a_vec;
    m = k / 2;
    if (!resetn) exp_addr = '0;
    e_en = 1'b0;
    if (m >= 1) begin
      p = (m - 1) % FT; h = p % HT; v = p / HT;
      if (h < 640 && v < VA) begin
        e_en = 1'b1;
        exp_addr = 15'((v / 4) * 160 + h / 4);
      end
    end
    e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0; e_r = '0; e_g = '0; e_b = '0;
    if (m >= 2) begin
      p = (m - 2) % FT; h = p % HT; v = p / HT;
      e_hs = !(h >= 656 && h < 752);
      e_vs = !(v >= VA + VFP && v < VA + VFP + VSY);
      if (h < 640 && v < VA) begin
        e_bl = 1'b1;
        col = pix_colour(h, v);
        e_r = {10{col[2]}}; e_g = {10{col[1]}}; e_b = {10{col[0]}};
      end
    end
    e_vc = k[0];
    e_vb = (k > 0) && (k % 2 == 0) && (m % FT == VA * HT);
    e_vec = {12'd0, e_vc, e_hs, e_vs, e_bl, 1'b0, e_vb, e_en, exp_addr, e_r, e_g, e_b};
    a_vec = {12'd0, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, vblank_start, rd_en,
             rd_addr, VGA_R, VGA_G, VGA_B};
    n_tests++;
    if (a_vec !== e_vec) begin
      n_fail++;
      $display("FAIL cycle_model k=%0d: got %h, expected %h", k, a_vec, e_vec);
    end
  end

  always @(negedge clk) begin
    if (meas_on && resetn) begin
      if (k >= 1 && k <= 3204 && !VGA_HS) hs_low_cnt++;
      if (k >= 1 && k <= 28804 && !VGA_VS) vs_low_cnt++;
      if (hs_prev && !VGA_HS) begin
        if (hs_fall1 < 0) hs_fall1 = k;
        else if (hs_fall2 < 0) hs_fall2 = k;
      end
      if (vs_prev && !VGA_VS) begin
        if (vs_fall1 < 0) vs_fall1 = k;
        else if (vs_fall2 < 0) vs_fall2 = k;
      end
      if (vblank_start) begin
        if (k <= 28800) vb_cnt++;
        if (vb1 < 0) vb1 = k;
        else if (vb2 < 0) vb2 = k;
      end
      hs_prev = VGA_HS;
      vs_prev = VGA_VS;
    end
  end

  initial begin
    int guard;
    for (int i = 0; i < 19200; i++) mem[i] = 3'(i % 7);
    mem[161] = 3'b101;
    resetn = 1'b0;
    #17;
    chk("rst_hs", int'(VGA_HS), 1);
    chk("rst_vs", int'(VGA_VS), 1);
    chk("rst_blank_n", int'(VGA_BLANK_N), 0);
    chk("rst_r", int'(VGA_R), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_vga_clk", int'(VGA_CLK), 0);
    chk("rst_vblank", int'(vblank_start), 0);
    chk("sync_n", int'(VGA_SYNC_N), 0);
    #5 resetn = 1'b1;

    wait_k(2);
    chk("addr_0_0", int'(rd_addr), 0);
    chk("rd_en_0_0", int'(rd_en), 1);
    wait_k(1280);
    chk("addr_639_0", int'(rd_addr), 159);
    wait_k(1282);
    chk("rd_en_h640", int'(rd_en), 0);
    wait_k(1404);
    chk("blank_rgb_r", int'(VGA_R), 0);
    chk("blank_rgb_g", int'(VGA_G), 0);
    chk("blank_n_off", int'(VGA_BLANK_N), 0);
    wait_k(6410);
    chk("addr_4_4", int'(rd_addr), 161);
    wait_k(8004);
    chk("edge_px_b", int'(VGA_B), EDGE_B);
    wait_k(8014);
    chk("px_5_5_r", int'(VGA_R), 1023);
    chk("px_5_5_g", int'(VGA_G), 0);
    chk("px_5_5_b", int'(VGA_B), 1023);
    chk("px_5_5_blank_n", int'(VGA_BLANK_N), 1);
    wait_k(11216);
    chk("addr_7_7", int'(rd_addr), 161);
    wait_k(18880);
    chk("addr_639_11", int'(rd_addr), 479);

    wait_k(51300);
    meas_on = 1'b0;
    chk("hs_low_2_lines", hs_low_cnt, 384);
    chk("hs_first_fall", hs_fall1, 1316);
    chk("line_period", hs_fall2 - hs_fall1, 1600);
    chk("vs_low_clks", vs_low_cnt, 3200);
    chk("vs_first_fall", vs_fall1, 22404);
    chk("frame_period_vs", vs_fall2 - vs_fall1, 28800);
    chk("vblank_per_frame", vb_cnt, 1);
    chk("vblank_first", vb1, 19200);
    chk("frame_period_vb", vb2 - vb1, 28800);

    // Asynchronous reset in the middle of an active line (h=300, v=5)
    wait_k(66200);
    chk("pre_rst_blank_n", int'(VGA_BLANK_N), 1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_hs", int'(VGA_HS), 1);
    chk("arst_blank_n", int'(VGA_BLANK_N), 0);
    chk("arst_r", int'(VGA_R), 0);
    chk("arst_rd_en", int'(rd_en), 0);
    chk("arst_rd_addr", int'(rd_addr), 0);
    chk("arst_vga_clk", int'(VGA_CLK), 0);
    #29 resetn = 1'b1;
    guard = 0;
    @(negedge clk);
    while (VGA_HS && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    chk("hs_fall_after_rst", k, 1316);
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Read side of the 160x120x3 framebuffer that the game datapath fills via the VGA adapter write port (x, y, colour, plot).
- Generates 640x480@60 timing from the 50 MHz clock and fetches framebuffer pixels, each replicated 4x4.
- Drives VGA DAC signals and gives control a vblank pulse so redraws can be synchronised to frame boundaries.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- SCALE_SHIFT, 2, log2 of pixel replication (4x4)
- FB_WIDTH, 160, framebuffer pixels per row

Ports:
- clk  in  1  50 MHz system clock
- resetn  in  1  asynchronous active-low reset
- rd_addr  out  15  framebuffer read address, y*160+x
- rd_en  out  1  read strobe
- rd_data  in  3  colour {R,G,B}, valid one clk after rd_addr/rd_en
- VGA_CLK  out  1  25 MHz pixel clock
- VGA_HS  out  1  hsync, active low
- VGA_VS  out  1  vsync, active low
- VGA_BLANK_N  out  1  high during active video
- VGA_SYNC_N  out  1  tied 0
- VGA_R, VGA_G, VGA_B  out  10 each  colour bit replicated to all 10 bits
- vblank_start  out  1  one-clk pulse at start of vertical front porch

Behaviour:
- Reset: asynchronous on resetn low. All outputs and state are cleared as follows:
  - Counters h_cnt=0, v_cnt=0; pix_en=0; VGA_CLK=0.
  - HS=VS=1, BLANK_N=0, RGB=0, rd_en=0, rd_addr=0, vblank_start=0.
  - On release, scanning starts at (0,0).
- Pixel enable: pix_en toggles every clk, so a pixel tick occurs every 2 clks. VGA_CLK = registered ~pix_en, so its rising edge is centred on stable data.
- Counters: advance only on pix_en.
  - h_cnt counts 0..799 and wraps to 0.
  - On h wrap, v_cnt counts 0..524 and wraps to 0.
  - h_total = H_ACTIVE+H_FP+H_SYNC+H_BP; v_total is defined likewise.
- Stage 0 (tick n): compute from the counters:
  - active = h_cnt<640 && v_cnt<480.
  - hs_raw low for h_cnt in [656,751]; vs_raw low for v_cnt in [490,491].
- Stage 1 (tick n, registered):
  - rd_addr = (v_cnt>>2)*160 + (h_cnt>>2), implemented as (fy<<7)+(fy<<5)+fx, 15 bits.
  - rd_en=active. When inactive, rd_addr holds its previous value.
- Stage 2 (tick n+1): sample rd_data. RAM latency is 1 clk, well inside one 2-clk tick.
- Stage 3 (tick n+2): registered outputs.
  - RGB = active_d2 ? {10{rd_data[2]}},{10{rd_data[1]}},{10{rd_data[0]}} : 0.
  - HS/VS/BLANK_N are delayed 2 ticks so all DAC outputs stay aligned. Total counter-to-pin latency is 2 pixel ticks.
- vblank_start: one clk high on the pix_en clk where v_cnt becomes 480 (h_cnt wraps 799->0 on line 479). Exactly one pulse per frame.
- Reset mid-frame: immediate return to reset values. No partial-line completion is required.
- Blanking: RGB must be 0 whenever BLANK_N=0, regardless of rd_data.

Optional Feature:
- Macro: SCANOUT_BORDER_EN.
- Defined: framebuffer pixels with fx==0, fx==159, fy==0 or fy==119 output colour 3'b111 instead of rd_data. rd_en still asserts normally. This provides a screen-alignment aid.
- Undefined: pure pass-through of rd_data. No border logic is synthesised.

Test Plan:
- Line timing: run 2 lines -> HS low exactly 192 clks per 1600-clk line; first HS fall 2 ticks after h_cnt reaches 656.
- Frame timing: run 1 frame -> VS low for 3200 clks; frame period 840000 clks; exactly one vblank_start pulse per frame, in the clk where v_cnt enters 480.
- Addressing: rd_addr at (h,v)=(0,0)=0, (4,4)=161, (7,7)=161, (639,479)=19199; rd_en=0 for h>=640 or v>=480.
- Data path: RAM model returns 3'b101 at addr 161 -> pixels (4..7,4..7) show VGA_R=10'h3FF, VGA_G=0, VGA_B=10'h3FF, aligned with BLANK_N=1; rd_data forced 3'b111 during blanking -> RGB=0.
- Reset: assert resetn=0 at (300,200) for 3 clks -> outputs return to reset values without waiting for clk; after release, first HS fall occurs 1312+4 clks later.
- SCANOUT_BORDER_EN: RAM all 3'b000 -> RGB all 3FF at screen pixel x 0..3 and 636..639, and on lines 0..3 and 476..479; interior RGB=0. With the macro undefined, the whole screen is 0.
